// File: rtl/mem_xfer_pkg.sv
// Shared types and helpers for the cache-line memory transfer engine.
package mem_xfer_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } xfer_state_e;

    function automatic int unsigned line_words(input int unsigned line_addr_len);
        return 32'd1 << line_addr_len;
    endfunction

endpackage

// File: rtl/mem_line_master.sv
// Line transfer engine: write-back and/or fill of one cache line against a
// word-addressed memory whose read data returns one cycle after the address.
module mem_line_master
    import mem_xfer_pkg::*;
#(
    parameter int unsigned ADDR_LEN      = 11,
    parameter int unsigned LINE_ADDR_LEN = 2,
    localparam int unsigned LINE_WORDS   = line_words(LINE_ADDR_LEN),
    localparam int unsigned LINE_W       = ADDR_LEN - LINE_ADDR_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic                         wb_en,
    input  logic                         fill_en,
    input  logic [LINE_W-1:0]            wb_line_addr,
    input  logic [LINE_W-1:0]            fill_line_addr,
    input  logic [LINE_WORDS*WORD_W-1:0] wb_data,
    output logic                         busy,
    output logic                         done,
    output logic [LINE_WORDS*WORD_W-1:0] fill_data,
    output logic [ADDR_LEN-1:0]          mem_addr,
    input  logic [WORD_W-1:0]            mem_rd_data,
    output logic                         mem_wr_req,
    output logic [WORD_W-1:0]            mem_wr_data
);

    xfer_state_e                           state_q, state_d;
    logic [LINE_ADDR_LEN-1:0]              cnt_q, cnt_d;
    logic [LINE_W-1:0]                     wb_line_q, wb_line_d;
    logic [LINE_W-1:0]                     fill_line_q, fill_line_d;
    logic                                  fill_en_q, fill_en_d;
    logic                                  done_q, done_d;
    logic [LINE_WORDS-1:0][WORD_W-1:0]     wb_data_q, wb_data_d;
    logic [LINE_WORDS-1:0][WORD_W-1:0]     fill_data_q, fill_data_d;
    logic [LINE_ADDR_LEN-1:0]              prev_cnt;

    assign prev_cnt  = cnt_q - 1'b1;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign fill_data = fill_data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wb_line_d   = wb_line_q;
        fill_line_d = fill_line_q;
        fill_en_d   = fill_en_q;
        wb_data_d   = wb_data_q;
        fill_data_d = fill_data_q;
        done_d      = 1'b0;
        mem_addr    = '0;
        mem_wr_req  = 1'b0;
        mem_wr_data = '0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    wb_line_d   = wb_line_addr;
                    fill_line_d = fill_line_addr;
                    wb_data_d   = wb_data;
                    fill_en_d   = fill_en;
                    cnt_d       = '0;
                    if (wb_en) begin
                        state_d = WB;
                    end else if (fill_en) begin
                        state_d = FILL;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WB: begin
                mem_addr    = {wb_line_q, cnt_q};
                mem_wr_req  = 1'b1;
                mem_wr_data = wb_data_q[cnt_q];
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    if (fill_en_q) begin
                        state_d = FILL;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            FILL: begin
                mem_addr = {fill_line_q, cnt_q};
                // Read data lags the address by one cycle, so word cnt-1 lands now.
                if (cnt_q != '0) begin
                    fill_data_d[prev_cnt] = mem_rd_data;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                fill_data_d[LINE_WORDS-1] = mem_rd_data;
                state_d                   = IDLE;
                done_d                    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wb_line_q   <= '0;
            fill_line_q <= '0;
            fill_en_q   <= 1'b0;
            done_q      <= 1'b0;
            wb_data_q   <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_line_q   <= wb_line_d;
            fill_line_q <= fill_line_d;
            fill_en_q   <= fill_en_d;
            done_q      <= done_d;
            wb_data_q   <= wb_data_d;
            fill_data_q <= fill_data_d;
        end
    end

endmodule

// File: tb/tb_mem_line_master.sv
// Directed bench for mem_line_master with a registered-read memory model
// preloaded with mem[a] = 0xC0DE0000 | a.
module tb_mem_line_master;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic         wb_en;
    logic         fill_en;
    logic [8:0]   wb_line_addr;
    logic [8:0]   fill_line_addr;
    logic [127:0] wb_data;
    logic         busy;
    logic         done;
    logic [127:0] fill_data;
    logic [10:0]  mem_addr;
    logic [31:0]  mem_rd_data;
    logic         mem_wr_req;
    logic [31:0]  mem_wr_data;

    logic [31:0]  mem [0:2047];
    int           wr_count = 0;
    int           n_pass = 0;
    int           n_total = 0;

    always #5 clk = ~clk;

    mem_line_master #(
        .ADDR_LEN(11),
        .LINE_ADDR_LEN(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .wb_en(wb_en),
        .fill_en(fill_en),
        .wb_line_addr(wb_line_addr),
        .fill_line_addr(fill_line_addr),
        .wb_data(wb_data),
        .busy(busy),
        .done(done),
        .fill_data(fill_data),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req),
        .mem_wr_data(mem_wr_data)
    );

    always @(posedge clk) begin
        if (mem_wr_req) begin
            mem[mem_addr] <= mem_wr_data;
            wr_count      <= wr_count + 1;
        end
        mem_rd_data <= mem[mem_addr];
    end

    typedef struct {
        string        name;
        logic         w;
        logic         f;
        logic [8:0]   wa;
        logic [8:0]   fa;
        logic [127:0] wd;
        int           exp_done;
        int           exp_busy;
        int           exp_wrs;
        logic         chk_fill;
        logic [127:0] exp_fill;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Call with time just after a posedge (cycle 0); returns just after a posedge.
    task automatic run_xfer(input vec_t v, output int dcyc, output int bcyc, output int wrs);
        int wr0;
        wr0            = wr_count;
        wb_en          = v.w;
        fill_en        = v.f;
        wb_line_addr   = v.wa;
        fill_line_addr = v.fa;
        wb_data        = v.wd;
        req            = 1'b1;
        dcyc           = -1;
        bcyc           = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            req = 1'b0;
            if (busy) bcyc++;
            if (done) begin
                dcyc = k;
                break;
            end
        end
        wrs = wr_count - wr0;
    endtask

    initial begin
        int dcyc, bcyc, wrs, ndone, d1, d2, wr0;
        logic bsy_next;

        for (int a = 0; a < 2048; a++) mem[a] <= 32'hC0DE0000 | 32'(a);

        vecs[0] = '{"fill16", 1'b0, 1'b1, 9'd0, 9'd16, 128'd0, 6, 5, 0, 1'b1,
                    {32'hC0DE0043, 32'hC0DE0042, 32'hC0DE0041, 32'hC0DE0040}};
        vecs[1] = '{"wb0", 1'b1, 1'b0, 9'd0, 9'd0,
                    {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    5, 4, 4, 1'b0, 128'd0};
        vecs[2] = '{"fill0", 1'b0, 1'b1, 9'd0, 9'd0, 128'd0, 6, 5, 0, 1'b1,
                    {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}};
        vecs[3] = '{"swap", 1'b1, 1'b1, 9'd32, 9'd47,
                    {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000},
                    10, 9, 4, 1'b1,
                    {32'hC0DE00BF, 32'hC0DE00BE, 32'hC0DE00BD, 32'hC0DE00BC}};
        vecs[4] = '{"noop", 1'b0, 1'b0, 9'd3, 9'd3, 128'd0, 1, 0, 0, 1'b0, 128'd0};
        vecs[5] = '{"fill511", 1'b0, 1'b1, 9'd0, 9'd511, 128'd0, 6, 5, 0, 1'b1,
                    {32'hC0DE07FF, 32'hC0DE07FE, 32'hC0DE07FD, 32'hC0DE07FC}};

        rst = 1'b1; req = 1'b0; wb_en = 1'b0; fill_en = 1'b0;
        wb_line_addr = '0; fill_line_addr = '0; wb_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_fill_data", fill_data, 128'd0);
        check("rst_mem_addr", 128'(mem_addr), 128'd0);
        check("rst_wr_req", 128'(mem_wr_req), 128'd0);
        check("rst_wr_data", 128'(mem_wr_data), 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i], dcyc, bcyc, wrs);
            check({vecs[i].name, "_done_cycle"}, 128'(dcyc), 128'(vecs[i].exp_done));
            check({vecs[i].name, "_busy_cycles"}, 128'(bcyc), 128'(vecs[i].exp_busy));
            check({vecs[i].name, "_writes"}, 128'(wrs), 128'(vecs[i].exp_wrs));
            if (vecs[i].chk_fill) check({vecs[i].name, "_fill_data"}, fill_data, vecs[i].exp_fill);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            check("wb_line32_mem", 128'(mem[128 + i]), 128'(32'hAAAA0000 + 32'(i)));
            check("fill511_nowrap_mem", 128'(mem[i]), 128'(32'h11111111 * 32'(i + 1)));
        end

        // A req while filling must be ignored.
        ndone = 0; wr0 = wr_count;
        wb_en = 1'b0; fill_en = 1'b1; fill_line_addr = 9'd1; req = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            req = 1'b0;
            if (k == 3) begin
                req = 1'b1; wb_en = 1'b1; wb_line_addr = 9'd5;
            end
            if (done) ndone++;
        end
        check("busy_req_done_count", 128'(ndone), 128'd1);
        check("busy_req_writes", 128'(wr_count - wr0), 128'd0);
        check("busy_req_fill", fill_data,
              {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004});

        // A req in the done cycle starts the next transfer with no gap.
        d1 = 0; d2 = 0; bsy_next = 1'b0;
        wb_en = 1'b0; fill_en = 1'b1; fill_line_addr = 9'd2; req = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            req = 1'b0;
            if (d1 > 0 && k == d1 + 1) bsy_next = busy;
            if (done) begin
                if (d1 == 0) begin
                    d1 = k; req = 1'b1; fill_line_addr = 9'd3;
                end else begin
                    d2 = k;
                    break;
                end
            end
        end
        check("b2b_first_done", 128'(d1), 128'd6);
        check("b2b_busy_after_done", 128'(bsy_next), 128'd1);
        check("b2b_second_done", 128'(d2), 128'd12);
        check("b2b_fill", fill_data,
              {32'hC0DE000F, 32'hC0DE000E, 32'hC0DE000D, 32'hC0DE000C});
        @(posedge clk);
        #1;

        // Reset in cycle 2 of a write-back to line 4 (addresses 16..19).
        wr0 = wr_count;
        wb_en = 1'b1; fill_en = 1'b0; wb_line_addr = 9'd4;
        wb_data = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_wr_req", 128'(mem_wr_req), 128'd0);
        check("rst_mid_busy", 128'(busy), 128'd0);
        check("rst_mid_done", 128'(done), 128'd0);
        check("rst_mid_fill_data", fill_data, 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_writes", 128'(wr_count - wr0), 128'd2);
        check("rst_mid_mem16", 128'(mem[16]), 128'(32'hDEAD0000));
        check("rst_mid_mem17", 128'(mem[17]), 128'(32'hDEAD0001));
        check("rst_mid_mem18", 128'(mem[18]), 128'(32'hC0DE0012));
        check("rst_mid_mem19", 128'(mem[19]), 128'(32'hC0DE0013));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
